// File: rtl/tomasulo_pkg.sv
// Shared types and default configuration for the Tomasulo dispatcher slice.
// Contents:
//   - default widths and counts for the dispatcher
//   - cls_t   : functional class of a reservation station / instruction
//   - src_t   : resolved source operand {rdy, tag, data}
//   - dispatch_t : dispatched payload {op, tag, src0, src1}
//   - RS_CLASS_DEF : default station-to-class map (station 0 in the LSBs)
package tomasulo_pkg;

    localparam int W_DEF      = 32;
    localparam int REGS_N_DEF = 32;
    localparam int RS_N_DEF   = 5;
    localparam int CLS_N_DEF  = 3;
    localparam int OP_W_DEF   = 4;
    localparam int RA_W_DEF   = $clog2(REGS_N_DEF);
    localparam int TAG_W_DEF  = $clog2(RS_N_DEF);
    localparam int CLS_W_DEF  = $clog2(CLS_N_DEF);

    typedef enum logic [CLS_W_DEF-1:0] {
        ARITH = 2'd0,
        LOGIC = 2'd1,
        MPY   = 2'd2
    } cls_t;

    typedef struct packed {
        logic                 rdy;
        logic [TAG_W_DEF-1:0] tag;
        logic [W_DEF-1:0]     data;
    } src_t;

    typedef struct packed {
        logic [OP_W_DEF-1:0]  op;
        logic [TAG_W_DEF-1:0] tag;
        src_t                 src0;
        src_t                 src1;
    } dispatch_t;

    // Two arithmetic stations, two logic stations, one multiplier.
    localparam logic [RS_N_DEF*CLS_W_DEF-1:0] RS_CLASS_DEF = {MPY, LOGIC, LOGIC, ARITH, ARITH};

endpackage

// File: rtl/tomasulo_reg_status.sv
// Architectural register file plus register status (busy/rename tag) table.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd0_*, rd1_*          : two combinational source read ports with CDB bypass
//   ren_en/ren_wa/ren_tag : rename port, marks ren_wa busy with producer ren_tag
//   cdb_vld/tag/data      : common data bus snoop, retires matching registers
//   out_vld_r/wa_r/wdata_r: registered record of the architectural writeback
module tomasulo_reg_status
    import tomasulo_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int REGS_N = REGS_N_DEF,
    parameter int RS_N   = RS_N_DEF,
    parameter int RA_W   = $clog2(REGS_N),
    parameter int TAG_W  = $clog2(RS_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  rd0_ra,
    output logic             rd0_rdy,
    output logic [TAG_W-1:0] rd0_tag,
    output logic [W-1:0]     rd0_data,
    input  logic [RA_W-1:0]  rd1_ra,
    output logic             rd1_rdy,
    output logic [TAG_W-1:0] rd1_tag,
    output logic [W-1:0]     rd1_data,
    input  logic             ren_en,
    input  logic [RA_W-1:0]  ren_wa,
    input  logic [TAG_W-1:0] ren_tag,
    input  logic             cdb_vld,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [W-1:0]     cdb_data,
    output logic             out_vld_r,
    output logic [RA_W-1:0]  out_wa_r,
    output logic [W-1:0]     out_wdata_r
);

    logic [W-1:0]      rf      [REGS_N];
    logic [TAG_W-1:0]  tag_tbl [REGS_N];
    logic [REGS_N-1:0] busy;
    logic [REGS_N-1:0] hit;
    logic              ret_vld;
    logic [RA_W-1:0]   ret_wa;

    // Find the register (at most one) still waiting on the broadcasting
    // station; stale tags of renamed-over registers no longer match.
    always_comb begin
        hit     = '0;
        ret_vld = 1'b0;
        ret_wa  = '0;
        for (int r = 0; r < REGS_N; r++) begin
            hit[r] = cdb_vld && busy[r] && (tag_tbl[r] == cdb_tag);
            if (hit[r]) begin
                ret_vld = 1'b1;
                ret_wa  = RA_W'(r);
            end
        end
    end

    // Source port 0: ready from the RF, ready via same-cycle CDB bypass,
    // or still pending on the producing station's tag.
    always_comb begin
        rd0_rdy  = 1'b1;
        rd0_tag  = '0;
        rd0_data = rf[rd0_ra];
        if (busy[rd0_ra]) begin
            rd0_tag = tag_tbl[rd0_ra];
            if (cdb_vld && (cdb_tag == tag_tbl[rd0_ra])) begin
                rd0_data = cdb_data;
            end else begin
                rd0_rdy  = 1'b0;
                rd0_data = '0;
            end
        end
    end

    // Source port 1: identical resolution rules to port 0.
    always_comb begin
        rd1_rdy  = 1'b1;
        rd1_tag  = '0;
        rd1_data = rf[rd1_ra];
        if (busy[rd1_ra]) begin
            rd1_tag = tag_tbl[rd1_ra];
            if (cdb_vld && (cdb_tag == tag_tbl[rd1_ra])) begin
                rd1_data = cdb_data;
            end else begin
                rd1_rdy  = 1'b0;
                rd1_data = '0;
            end
        end
    end

    // Retire writes the RF and frees the register; a rename in the same
    // cycle is assigned later so it keeps the register busy with the new tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REGS_N; r++) begin
                rf[r]      <= '0;
                tag_tbl[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < REGS_N; r++) begin
                if (hit[r]) begin
                    rf[r]   <= cdb_data;
                    busy[r] <= 1'b0;
                end
                if (ren_en && (ren_wa == RA_W'(r))) begin
                    busy[r]    <= 1'b1;
                    tag_tbl[r] <= ren_tag;
                end
            end
        end
    end

    // Registered writeback record; the register/data fields hold between
    // retirements so only out_vld_r marks a fresh writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r   <= 1'b0;
            out_wa_r    <= '0;
            out_wdata_r <= '0;
        end else begin
            out_vld_r <= ret_vld;
            if (ret_vld) begin
                out_wa_r    <= ret_wa;
                out_wdata_r <= cdb_data;
            end
        end
    end

endmodule

// File: rtl/tomasulo_dispatcher_n.sv
// In-order dispatcher feeding RS_N reservation stations grouped by class.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cdb_*             : common data bus snoop (bypass and retirement)
//   inst_*            : incoming instruction; inst_adv acknowledges it
//   rs_full_r         : per-station occupancy from the stations
//   dis_*_r           : registered one-hot dispatch strobe and payload
//   out_*_r           : registered architectural writeback record
module tomasulo_dispatcher_n
    import tomasulo_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int REGS_N = REGS_N_DEF,
    parameter int RS_N   = RS_N_DEF,
    parameter int CLS_N  = CLS_N_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int RA_W   = $clog2(REGS_N),
    parameter int TAG_W  = $clog2(RS_N),
    parameter int CLS_W  = $clog2(CLS_N),
    parameter logic [RS_N*CLS_W-1:0] RS_CLASS = RS_CLASS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cdb_vld,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [W-1:0]     cdb_data,
    input  logic             inst_vld,
    input  logic [OP_W-1:0]  inst_op,
    input  logic [CLS_W-1:0] inst_cls,
    input  logic [RA_W-1:0]  inst_wa,
    input  logic [RA_W-1:0]  inst_ra0,
    input  logic [RA_W-1:0]  inst_ra1,
    output logic             inst_adv,
    input  logic [RS_N-1:0]  rs_full_r,
    output logic [RS_N-1:0]  dis_vld_r,
    output logic [OP_W-1:0]  dis_op_r,
    output logic [TAG_W-1:0] dis_tag_r,
    output logic             dis_src0_rdy_r,
    output logic [TAG_W-1:0] dis_src0_tag_r,
    output logic [W-1:0]     dis_src0_data_r,
    output logic             dis_src1_rdy_r,
    output logic [TAG_W-1:0] dis_src1_tag_r,
    output logic [W-1:0]     dis_src1_data_r,
    output logic             out_vld_r,
    output logic [RA_W-1:0]  out_wa_r,
    output logic [W-1:0]     out_wdata_r
);

    logic             any_elig;
    logic [TAG_W-1:0] sel;
    logic             s0_rdy, s1_rdy;
    logic [TAG_W-1:0] s0_tag, s1_tag;
    logic [W-1:0]     s0_data, s1_data;

    // Pick the lowest-index station of the requested class that is free.
    // A station strobed last cycle is treated as full because the station's
    // own full flag only rises one cycle after the strobe.
    always_comb begin
        any_elig = 1'b0;
        sel      = '0;
        for (int i = RS_N - 1; i >= 0; i--) begin
            if ((RS_CLASS[i*CLS_W +: CLS_W] == inst_cls) && !rs_full_r[i] && !dis_vld_r[i]) begin
                any_elig = 1'b1;
                sel      = TAG_W'(i);
            end
        end
    end

    assign inst_adv = inst_vld && any_elig;

    tomasulo_reg_status #(
        .W      (W),
        .REGS_N (REGS_N),
        .RS_N   (RS_N),
        .RA_W   (RA_W),
        .TAG_W  (TAG_W)
    ) u_reg_status (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd0_ra      (inst_ra0),
        .rd0_rdy     (s0_rdy),
        .rd0_tag     (s0_tag),
        .rd0_data    (s0_data),
        .rd1_ra      (inst_ra1),
        .rd1_rdy     (s1_rdy),
        .rd1_tag     (s1_tag),
        .rd1_data    (s1_data),
        .ren_en      (inst_adv),
        .ren_wa      (inst_wa),
        .ren_tag     (sel),
        .cdb_vld     (cdb_vld),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .out_vld_r   (out_vld_r),
        .out_wa_r    (out_wa_r),
        .out_wdata_r (out_wdata_r)
    );

    // Dispatch register: the strobe is one-hot for a single cycle, while the
    // payload is only captured on a dispatch and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_vld_r       <= '0;
            dis_op_r        <= '0;
            dis_tag_r       <= '0;
            dis_src0_rdy_r  <= 1'b0;
            dis_src0_tag_r  <= '0;
            dis_src0_data_r <= '0;
            dis_src1_rdy_r  <= 1'b0;
            dis_src1_tag_r  <= '0;
            dis_src1_data_r <= '0;
        end else begin
            dis_vld_r <= inst_adv ? (RS_N'(1) << sel) : '0;
            if (inst_adv) begin
                dis_op_r        <= inst_op;
                dis_tag_r       <= sel;
                dis_src0_rdy_r  <= s0_rdy;
                dis_src0_tag_r  <= s0_tag;
                dis_src0_data_r <= s0_data;
                dis_src1_rdy_r  <= s1_rdy;
                dis_src1_tag_r  <= s1_tag;
                dis_src1_data_r <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_tomasulo_dispatcher_n.sv
// Self-checking bench for tomasulo_dispatcher_n with the default configuration.
// A behavioural register/station model predicts every registered output and
// inst_adv each cycle; directed scenarios add literal expectations.
module tb_tomasulo_dispatcher_n;
    import tomasulo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cdb_vld;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        inst_vld;
    logic [3:0]  inst_op;
    logic [1:0]  inst_cls;
    logic [4:0]  inst_wa;
    logic [4:0]  inst_ra0;
    logic [4:0]  inst_ra1;
    logic        inst_adv;
    logic [4:0]  rs_full_r;
    logic [4:0]  dis_vld_r;
    logic [3:0]  dis_op_r;
    logic [2:0]  dis_tag_r;
    logic        dis_src0_rdy_r;
    logic [2:0]  dis_src0_tag_r;
    logic [31:0] dis_src0_data_r;
    logic        dis_src1_rdy_r;
    logic [2:0]  dis_src1_tag_r;
    logic [31:0] dis_src1_data_r;
    logic        out_vld_r;
    logic [4:0]  out_wa_r;
    logic [31:0] out_wdata_r;

    int checks = 0;
    int errors = 0;
    logic last_adv;

    tomasulo_dispatcher_n dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cdb_vld         (cdb_vld),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .inst_vld        (inst_vld),
        .inst_op         (inst_op),
        .inst_cls        (inst_cls),
        .inst_wa         (inst_wa),
        .inst_ra0        (inst_ra0),
        .inst_ra1        (inst_ra1),
        .inst_adv        (inst_adv),
        .rs_full_r       (rs_full_r),
        .dis_vld_r       (dis_vld_r),
        .dis_op_r        (dis_op_r),
        .dis_tag_r       (dis_tag_r),
        .dis_src0_rdy_r  (dis_src0_rdy_r),
        .dis_src0_tag_r  (dis_src0_tag_r),
        .dis_src0_data_r (dis_src0_data_r),
        .dis_src1_rdy_r  (dis_src1_rdy_r),
        .dis_src1_tag_r  (dis_src1_tag_r),
        .dis_src1_data_r (dis_src1_data_r),
        .out_vld_r       (out_vld_r),
        .out_wa_r        (out_wa_r),
        .out_wdata_r     (out_wdata_r)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, sample inst_adv before the edge, then return
    // just after the edge so the registered results are visible.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] cls,
                                 input logic [4:0] wa, input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic [4:0] full, input logic cv, input logic [2:0] ct,
                                 input logic [31:0] cd);
        inst_vld  = v;
        inst_op   = op;
        inst_cls  = cls;
        inst_wa   = wa;
        inst_ra0  = ra0;
        inst_ra1  = ra1;
        rs_full_r = full;
        cdb_vld   = cv;
        cdb_tag   = ct;
        cdb_data  = cd;
        #1;
        last_adv = inst_adv;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic cv, input logic [2:0] ct, input logic [31:0] cd);
        applyStimulus(1'b0, 4'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, cv, ct, cd);
    endtask

    // Behavioural model state.
    int          model_cls [5] = '{0, 0, 1, 1, 2};
    logic [31:0] m_rf   [32];
    bit          m_busy [32];
    int          m_tag  [32];
    logic [4:0]  e_dis_vld;
    dispatch_t   e_dis;
    bit          e_out_vld;
    int          e_out_wa;
    logic [31:0] e_out_data;

    function automatic src_t resolve(input int ra);
        src_t s;
        s = '0;
        if (!m_busy[ra]) begin
            s.rdy  = 1'b1;
            s.data = m_rf[ra];
        end else if (cdb_vld && (int'(cdb_tag) == m_tag[ra])) begin
            s.rdy  = 1'b1;
            s.data = cdb_data;
        end else begin
            s.rdy = 1'b0;
            s.tag = 3'(m_tag[ra]);
        end
        return s;
    endfunction

    // Compare process: on every falling edge check the registered outputs
    // against the model's prediction, then advance the model with the
    // inputs that the next rising edge will capture.
    always @(negedge clk) begin
        int   sel;
        src_t s0, s1;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_rf[r]   = '0;
                m_busy[r] = 1'b0;
                m_tag[r]  = 0;
            end
            e_dis_vld = '0;
            e_out_vld = 1'b0;
            e_dis     = '0;
            checkOutput("rst_dis_vld", dis_vld_r, 0);
            checkOutput("rst_out_vld", out_vld_r, 0);
        end else begin
            checkOutput("dis_vld", dis_vld_r, e_dis_vld);
            if (e_dis_vld != 5'd0) begin
                checkOutput("dis_op", dis_op_r, e_dis.op);
                checkOutput("dis_tag", dis_tag_r, e_dis.tag);
                checkOutput("src0_rdy", dis_src0_rdy_r, e_dis.src0.rdy);
                if (e_dis.src0.rdy) checkOutput("src0_data", dis_src0_data_r, e_dis.src0.data);
                else                checkOutput("src0_tag", dis_src0_tag_r, e_dis.src0.tag);
                checkOutput("src1_rdy", dis_src1_rdy_r, e_dis.src1.rdy);
                if (e_dis.src1.rdy) checkOutput("src1_data", dis_src1_data_r, e_dis.src1.data);
                else                checkOutput("src1_tag", dis_src1_tag_r, e_dis.src1.tag);
            end
            checkOutput("out_vld", out_vld_r, e_out_vld);
            if (e_out_vld) begin
                checkOutput("out_wa", out_wa_r, e_out_wa);
                checkOutput("out_wdata", out_wdata_r, e_out_data);
            end

            sel = -1;
            for (int i = 0; i < 5; i++) begin
                if (sel < 0 && model_cls[i] == int'(inst_cls) && !rs_full_r[i] && !e_dis_vld[i]) sel = i;
            end
            checkOutput("inst_adv", inst_adv, (inst_vld && sel >= 0));

            s0 = resolve(int'(inst_ra0));
            s1 = resolve(int'(inst_ra1));

            e_out_vld = 1'b0;
            for (int r = 0; r < 32; r++) begin
                if (cdb_vld && m_busy[r] && m_tag[r] == int'(cdb_tag)) begin
                    m_rf[r]    = cdb_data;
                    m_busy[r]  = 1'b0;
                    e_out_vld  = 1'b1;
                    e_out_wa   = r;
                    e_out_data = cdb_data;
                end
            end

            if (inst_vld && sel >= 0) begin
                e_dis.op   = inst_op;
                e_dis.tag  = 3'(sel);
                e_dis.src0 = s0;
                e_dis.src1 = s1;
                e_dis_vld  = 5'(1 << sel);
                m_busy[int'(inst_wa)] = 1'b1;
                m_tag[int'(inst_wa)]  = sel;
            end else begin
                e_dis_vld = '0;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        rst_n = 1'b0;
        inst_vld = 0; inst_op = 0; inst_cls = 0; inst_wa = 0; inst_ra0 = 0; inst_ra1 = 0;
        rs_full_r = 0; cdb_vld = 0; cdb_tag = 0; cdb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dis_vld", dis_vld_r, 0);
        checkOutput("reset_out_vld", out_vld_r, 0);
        checkOutput("reset_dis_op", dis_op_r, 0);
        checkOutput("reset_out_wdata", out_wdata_r, 0);
        rst_n = 1'b1;

        applyStimulus(1, 4'd1, 2'd0, 5'd3, 5'd1, 5'd2, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("t1_adv", last_adv, 1);
        checkOutput("t1_dis_vld", dis_vld_r, 5'b00001);
        checkOutput("t1_tag", dis_tag_r, 0);
        checkOutput("t1_src0_rdy", dis_src0_rdy_r, 1);
        checkOutput("t1_src0_data", dis_src0_data_r, 0);
        checkOutput("t1_src1_rdy", dis_src1_rdy_r, 1);
        idleCycle(1, 3'd0, 32'h55);
        checkOutput("t2_out_vld", out_vld_r, 1);
        checkOutput("t2_out_wa", out_wa_r, 3);
        checkOutput("t2_out_wdata", out_wdata_r, 32'h55);

        applyStimulus(1, 4'd2, 2'd0, 5'd10, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        applyStimulus(1, 4'd2, 2'd0, 5'd11, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("b2_dis_vld", dis_vld_r, 5'b00010);
        applyStimulus(1, 4'd2, 2'd0, 5'd12, 5'd0, 5'd0, 5'b00011, 0, 3'd0, 32'h0);
        checkOutput("b3_stall_adv", last_adv, 0);
        checkOutput("b3_dis_vld", dis_vld_r, 0);
        applyStimulus(1, 4'd2, 2'd0, 5'd12, 5'd0, 5'd0, 5'b00011, 1, 3'd0, 32'h10);
        checkOutput("b4_stall_adv", last_adv, 0);
        checkOutput("b4_out_wa", out_wa_r, 10);
        applyStimulus(1, 4'd2, 2'd0, 5'd12, 5'd0, 5'd0, 5'b00010, 1, 3'd1, 32'h11);
        checkOutput("b5_adv", last_adv, 1);
        checkOutput("b5_dis_vld", dis_vld_r, 5'b00001);
        checkOutput("b5_out_wdata", out_wdata_r, 32'h11);
        idleCycle(1, 3'd0, 32'h12);

        applyStimulus(1, 4'd3, 2'd0, 5'd5, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        applyStimulus(1, 4'd4, 2'd0, 5'd6, 5'd5, 5'd3, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("d2_src0_rdy", dis_src0_rdy_r, 0);
        checkOutput("d2_src0_tag", dis_src0_tag_r, 0);
        checkOutput("d2_src1_data", dis_src1_data_r, 32'h55);
        idleCycle(1, 3'd0, 32'h77);
        idleCycle(1, 3'd1, 32'h66);
        applyStimulus(1, 4'd3, 2'd0, 5'd5, 5'd6, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("d5_src0_data", dis_src0_data_r, 32'h66);
        applyStimulus(1, 4'd4, 2'd0, 5'd8, 5'd5, 5'd0, 5'b00000, 1, 3'd0, 32'hAB);
        checkOutput("d6_bypass_rdy", dis_src0_rdy_r, 1);
        checkOutput("d6_bypass_data", dis_src0_data_r, 32'hAB);
        checkOutput("d6_out_wa", out_wa_r, 5);
        idleCycle(1, 3'd1, 32'h88);

        applyStimulus(1, 4'd5, 2'd0, 5'd7, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        applyStimulus(1, 4'd5, 2'd0, 5'd7, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        idleCycle(1, 3'd0, 32'h1);
        checkOutput("w3_stale_out_vld", out_vld_r, 0);
        idleCycle(1, 3'd1, 32'h9);
        checkOutput("w4_out_wa", out_wa_r, 7);
        checkOutput("w4_out_wdata", out_wdata_r, 32'h9);
        applyStimulus(1, 4'd6, 2'd1, 5'd20, 5'd7, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("w5_dis_vld", dis_vld_r, 5'b00100);
        checkOutput("w5_src0_data", dis_src0_data_r, 32'h9);
        idleCycle(1, 3'd2, 32'h20);

        applyStimulus(1, 4'd7, 2'd1, 5'd4, 5'd0, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        applyStimulus(1, 4'd7, 2'd1, 5'd4, 5'd4, 5'd0, 5'b00000, 1, 3'd2, 32'h44);
        checkOutput("s2_dis_vld", dis_vld_r, 5'b01000);
        checkOutput("s2_src0_data", dis_src0_data_r, 32'h44);
        checkOutput("s2_out_vld", out_vld_r, 1);
        checkOutput("s2_out_wa", out_wa_r, 4);
        applyStimulus(1, 4'd8, 2'd2, 5'd21, 5'd4, 5'd0, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("s3_dis_vld", dis_vld_r, 5'b10000);
        checkOutput("s3_src0_rdy", dis_src0_rdy_r, 0);
        checkOutput("s3_src0_tag", dis_src0_tag_r, 3);

        applyStimulus(1, 4'd9, 2'd0, 5'd9, 5'd0, 5'd0, 5'b00000, 1, 3'd3, 32'h33);
        checkOutput("r1_dis_vld", dis_vld_r, 5'b00001);
        checkOutput("r1_out_vld", out_vld_r, 1);
        inst_vld = 0; cdb_vld = 0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dis_vld", dis_vld_r, 0);
        checkOutput("midrst_out_vld", out_vld_r, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 4'd1, 2'd0, 5'd1, 5'd21, 5'd9, 5'b00000, 0, 3'd0, 32'h0);
        checkOutput("r2_src0_rdy", dis_src0_rdy_r, 1);
        checkOutput("r2_src0_data", dis_src0_data_r, 0);
        checkOutput("r2_src1_rdy", dis_src1_rdy_r, 1);
        idleCycle(0, 3'd0, 32'h0);
        idleCycle(0, 3'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
